// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer sequencer: state encoding and mode constants.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl.sv
// Interval-timer sequencer: drives an external loadable up-counter through ld/en/D
// and watches its Q to produce periodic ticks or a single one-shot completion.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            stop,
  input  logic            mode,
  input  logic [Size-1:0] period,
  output logic            busy,
  output logic            tick,
  output logic            done,
  output logic            err,
  output logic            cnt_ld,
  output logic            cnt_en,
  output logic [Size-1:0] cnt_d,
  input  logic [Size-1:0] cnt_q
);

  localparam logic [Size-1:0] ONE = {{(Size-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic [Size-1:0] period_r;
  logic            mode_r;
  logic            err_r;
  logic            err_nxt;
  logic            latch;
  logic [Size-1:0] period_m1;
  logic            terminal;

  // Terminal count: the counter has reached P-1 (period_r is never 0 while running).
  always_comb begin
    period_m1 = period_r - ONE;
    terminal  = (cnt_q == period_m1);
  end

  // Next-state and counter-control decode; stop outranks terminal in LOAD/RUN.
  always_comb begin
    state_nxt = state;
    cnt_ld    = 1'b0;
    cnt_en    = 1'b0;
    tick      = 1'b0;
    err_nxt   = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (period != {Size{1'b0}}) begin
            latch     = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_ld    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (terminal) begin
          tick = 1'b1;
          if (mode_r == MODE_PERIODIC) begin
            cnt_ld = 1'b1;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, run configuration and the registered reject pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      period_r <= {Size{1'b0}};
      mode_r   <= MODE_ONESHOT;
      err_r    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_r <= err_nxt;
      if (latch) begin
        period_r <= period;
        mode_r   <= mode;
      end
    end
  end

  assign busy  = (state == S_LOAD) || (state == S_RUN);
  assign done  = (state == S_DONE);
  assign err   = err_r;
  assign cnt_d = {Size{1'b0}};

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural loadable up-counter attached.
module tb_timer_ctrl;

  localparam int Size = 8;

  logic            clk;
  logic            clr;
  logic            rst_n;
  logic            start;
  logic            stop;
  logic            mode;
  logic [Size-1:0] period;
  logic            busy;
  logic            tick;
  logic            done;
  logic            err;
  logic            cnt_ld;
  logic            cnt_en;
  logic [Size-1:0] cnt_d;
  logic [Size-1:0] cnt_q;

  int n_vec;
  int n_bad;

  timer_ctrl #(.Size(Size)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .mode(mode), .period(period),
    .busy(busy), .tick(tick), .done(done), .err(err),
    .cnt_ld(cnt_ld), .cnt_en(cnt_en), .cnt_d(cnt_d), .cnt_q(cnt_q)
  );

  // External counter: ld has priority over en; reset only by the system reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_q + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present start at the current negedge (cycle 0), advance into cycle 1 and drop start.
  task automatic go(input int p, input logic m);
    start  = 1'b1;
    period = 8'(p);
    mode   = m;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    clr = 1'b1; rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; period = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0; rst_n = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_err", 32'(err), 0);
    check_val("rst_ld", 32'(cnt_ld), 0);
    check_val("rst_en", 32'(cnt_en), 0);
    check_val("rst_d", 32'(cnt_d), 0);
    next_cyc();

    // One-shot, P=5
    go(5, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) next_cyc();
      check_val($sformatf("os5_tick_c%0d", k), 32'(tick), 32'(k == 6));
      check_val($sformatf("os5_done_c%0d", k), 32'(done), 32'(k == 7));
      check_val($sformatf("os5_busy_c%0d", k), 32'(busy), 32'(k <= 6));
      if (k >= 2) check_val($sformatf("os5_q_c%0d", k), 32'(cnt_q), (k <= 6) ? k - 2 : 4);
    end
    next_cyc();

    // Periodic, P=3; start with other settings during the run is ignored
    go(3, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      start  = (k >= 2 && k <= 5);
      period = 8'd7;
      mode   = 1'b0;
      #1;
      check_val($sformatf("per3_tick_c%0d", k), 32'(tick), 32'(k >= 4 && (k - 4) % 3 == 0));
      check_val($sformatf("per3_busy_c%0d", k), 32'(busy), 1);
      check_val($sformatf("per3_done_c%0d", k), 32'(done), 0);
      if (k >= 2) check_val($sformatf("per3_q_c%0d", k), 32'(cnt_q), (k - 2) % 3);
    end
    start = 1'b0;
    @(negedge clk); stop = 1'b1; #1;
    check_val("per3_stop_tick", 32'(tick), 0);
    next_cyc(); stop = 1'b0;
    check_val("per3_stop_busy", 32'(busy), 0);
    next_cyc();

    // Periodic, P=3, stop in cycle 6
    go(3, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      stop = (k == 6);
      #1;
      check_val($sformatf("stp_tick_c%0d", k), 32'(tick), 32'(k == 4));
      check_val($sformatf("stp_busy_c%0d", k), 32'(busy), 32'(k <= 6));
      check_val($sformatf("stp_done_c%0d", k), 32'(done), 0);
      if (k == 6) check_val("stp_en_c6", 32'(cnt_en), 0);
      if (k == 6) check_val("stp_ld_c6", 32'(cnt_ld), 0);
    end
    stop = 1'b0;
    next_cyc();

    // period == 0 is rejected
    go(0, 1'b0);
    check_val("err_c1", 32'(err), 1);
    check_val("err_busy_c1", 32'(busy), 0);
    check_val("err_ld_c1", 32'(cnt_ld), 0);
    check_val("err_en_c1", 32'(cnt_en), 0);
    next_cyc();
    check_val("err_c2", 32'(err), 0);
    check_val("err_busy_c2", 32'(busy), 0);
    next_cyc();

    // One-shot, P=1
    go(1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) next_cyc();
      check_val($sformatf("os1_tick_c%0d", k), 32'(tick), 32'(k == 2));
      check_val($sformatf("os1_done_c%0d", k), 32'(done), 32'(k == 3));
    end
    next_cyc();

    // Periodic, P=1
    go(1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) next_cyc();
      check_val($sformatf("per1_tick_c%0d", k), 32'(tick), 32'(k >= 2));
      check_val($sformatf("per1_ld_c%0d", k), 32'(cnt_ld), 1);
      if (k >= 2) check_val($sformatf("per1_q_c%0d", k), 32'(cnt_q), 0);
    end
    @(negedge clk); stop = 1'b1;
    next_cyc(); stop = 1'b0;
    check_val("per1_stop_busy", 32'(busy), 0);
    next_cyc();

    // Maximum period, one-shot
    go(255, 1'b0);
    for (int k = 1; k <= 258; k++) begin
      if (k > 1) next_cyc();
      if (tick || k == 256) check_val($sformatf("max_tick_c%0d", k), 32'(tick), 32'(k == 256));
      if (done || k == 257) check_val($sformatf("max_done_c%0d", k), 32'(done), 32'(k == 257));
      if (k == 256) check_val("max_q_c256", 32'(cnt_q), 254);
    end
    next_cyc();

    // start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1; period = 8'd4; mode = 1'b0;
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    check_val("ss_busy_c1", 32'(busy), 1);
    check_val("ss_ld_c1", 32'(cnt_ld), 1);
    for (int k = 2; k <= 6; k++) begin
      next_cyc();
      check_val($sformatf("ss_tick_c%0d", k), 32'(tick), 32'(k == 5));
      check_val($sformatf("ss_done_c%0d", k), 32'(done), 32'(k == 6));
    end
    next_cyc();

    // stop during LOAD
    start = 1'b1; period = 8'd4; mode = 1'b0;
    @(negedge clk); start = 1'b0; stop = 1'b1; #1;
    check_val("sl_busy_c1", 32'(busy), 1);
    check_val("sl_ld_c1", 32'(cnt_ld), 0);
    next_cyc(); stop = 1'b0;
    check_val("sl_busy_c2", 32'(busy), 0);
    check_val("sl_done_c2", 32'(done), 0);
    next_cyc();

    // clr mid-run at cnt_q=50, then a fresh P=2 run
    go(200, 1'b1);
    for (int k = 2; k <= 52; k++) next_cyc();
    check_val("clr_q_c52", 32'(cnt_q), 50);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0; #1;
    check_val("clr_busy", 32'(busy), 0);
    check_val("clr_tick", 32'(tick), 0);
    check_val("clr_done", 32'(done), 0);
    check_val("clr_err", 32'(err), 0);
    check_val("clr_ld", 32'(cnt_ld), 0);
    check_val("clr_en", 32'(cnt_en), 0);
    go(2, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) next_cyc();
      check_val($sformatf("p2_tick_c%0d", k), 32'(tick), 32'(k == 3));
      check_val($sformatf("p2_done_c%0d", k), 32'(done), 32'(k == 4));
      if (k == 2) check_val("p2_q_c2", 32'(cnt_q), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
